// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Brief    : FIFO-buffered UART transmitter, 5-8 data bits, none/odd/even
//            parity, 1 or 2 stop bits, back-to-back frame streaming.
// Revision : 1.0
// ============================================================================
module uart_tx_frame #(
  parameter int CLK_FRE    = 200_000_000,
  parameter int BPS        = 9_600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_txd,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BPS_CNT = CLK_FRE / BPS;
  localparam int CNT_W   = $clog2(BPS_CNT);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BPS_CNT - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0]    FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [7:0]       DATA_MASK = 8'(9'h1FF >> (9 - DATA_BITS));
  // Out-of-range PARITY values fall back to no parity.
  localparam bit               PAR_EN    = (PARITY == 1) || (PARITY == 2);
  localparam bit               PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             txd_q, txd_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             bit_done;
  logic             head_parity;

  assign fifo_empty  = (count_q == '0);
  assign tx_ready    = (count_q != FIFO_FULL);
  assign fifo_push   = tx_valid && tx_ready;
  assign bit_done    = (clk_cnt_q == CNT_LAST);
  assign head_parity = PAR_ODD ^ (^(mem_q[rd_ptr_q] & DATA_MASK));

  always_ff @(posedge sys_clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    fifo_pop  = 1'b0;
    txd_d     = 1'b1;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            state_d   = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        // bit_idx_q counts stop bits here; the last one chains straight into the next start bit.
        if (bit_done) begin
          clk_cnt_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              state_d  = S_START;
            end else begin
              state_d  = S_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    if (fifo_pop) begin
      shift_d = mem_q[rd_ptr_q];
      par_d   = head_parity;
    end

    // Line level is derived from the next state so uart_txd changes on the transition edge.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[bit_idx_d];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
    end
  end

  assign uart_txd   = txd_q;
  assign tx_busy    = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Brief    : Three frame formats (8N1/16, 8E1/4, 7O2/4) on shared stimulus,
//            each compared every cycle against a line-waveform model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_frame;

  localparam int NDUT    = 3;
  localparam int CLK_FRE = 1_000_000;
  localparam int BPS     = 100_000;
  localparam int BPS_CNT = CLK_FRE / BPS;

  logic                 sys_clk;
  logic                 sys_rst_n;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic [NDUT-1:0]      txd_a;
  logic [NDUT-1:0]      ready_a;
  logic [NDUT-1:0]      busy_a;
  logic [NDUT-1:0][4:0] cnt_a;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int DBK = (k == 2) ? 7 : 8;
    localparam int PK  = (k == 0) ? 0 : ((k == 1) ? 2 : 1);
    localparam int SK  = (k == 2) ? 2 : 1;
    localparam int FDK = (k == 0) ? 16 : 4;

    logic [$clog2(FDK):0] fc;
    logic [7:0]           bq[$];
    logic                 wave[$];
    int                   n0;
    logic [7:0]           sh;
    logic                 p;

    uart_tx_frame #(
      .CLK_FRE    (CLK_FRE),
      .BPS        (BPS),
      .DATA_BITS  (DBK),
      .PARITY     (PK),
      .STOP_BITS  (SK),
      .FIFO_DEPTH (FDK)
    ) u_dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (ready_a[k]),
      .uart_txd   (txd_a[k]),
      .tx_busy    (busy_a[k]),
      .fifo_count (fc)
    );

    assign cnt_a[k] = 5'(fc);

    // Model: byte queue plus the remaining per-clock line levels of the frame on the wire.
    initial forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        bq.delete();
        wave.delete();
      end else begin
        n0 = bq.size();
        if (wave.size() > 0) void'(wave.pop_front());
        if (wave.size() == 0 && n0 > 0) begin
          sh = bq.pop_front();
          p  = (PK == 1);
          repeat (BPS_CNT) wave.push_back(1'b0);
          for (int i = 0; i < DBK; i++) begin
            p = p ^ sh[0];
            repeat (BPS_CNT) wave.push_back(sh[0]);
            sh = sh >> 1;
          end
          if (PK == 1 || PK == 2) repeat (BPS_CNT) wave.push_back(p);
          repeat (SK * BPS_CNT) wave.push_back(1'b1);
        end
        if (tx_valid && n0 != FDK) bq.push_back(tx_data);
      end
    end

    initial forever begin
      @(negedge sys_clk);
      chk($sformatf("d%0d_txd", k), int'(txd_a[k]), (wave.size() > 0) ? int'(wave[0]) : 1);
      chk($sformatf("d%0d_count", k), int'(fc), bq.size());
      chk($sformatf("d%0d_ready", k), int'(ready_a[k]), (bq.size() != FDK) ? 1 : 0);
      chk($sformatf("d%0d_busy", k), int'(busy_a[k]), (wave.size() > 0 || bq.size() > 0) ? 1 : 0);
    end
  end

  task automatic send1(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int t;
    t = 0;
    while (busy_a != '0 && t < budget) begin
      @(negedge sys_clk);
      t++;
    end
    chk(nm, (busy_a == '0) ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_total=%0d", n_total);
    $fatal(1);
  end

  initial begin
    logic [9:0] f55;
    int         acc0;
    int         t;

    f55       = 10'b10_1010_1010;
    acc0      = 0;
    sys_rst_n = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    repeat (3) @(negedge sys_clk);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_txd%0d", k), txd_a[k], 1);
      chk($sformatf("rst_ready%0d", k), ready_a[k], 1);
      chk($sformatf("rst_busy%0d", k), busy_a[k], 0);
      chk($sformatf("rst_count%0d", k), cnt_a[k], 0);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // 0x55 on 8N1
    send1(8'h55);
    chk("A_count_after_accept", cnt_a[0], 1);
    chk("A_txd_before_pop", txd_a[0], 1);
    @(negedge sys_clk);
    chk("A_start_edge", txd_a[0], 0);
    chk("A_count_after_pop", cnt_a[0], 0);
    for (int s = 1; s <= 100; s++) begin
      @(negedge sys_clk);
      if (s % 10 == 5) chk($sformatf("A_bit%0d", s / 10), txd_a[0], f55[s / 10]);
      if (s == 99) chk("A_busy_last_stop", busy_a[0], 1);
    end
    chk("A_idle_after_frame", txd_a[0], 1);
    chk("A_busy_fall", busy_a[0], 0);
    wait_idle("A_drain", 500);

    // 0x07: even parity 1 (8E1), odd parity 0 (7O2)
    send1(8'h07);
    @(negedge sys_clk);
    for (int s = 1; s <= 110; s++) begin
      @(negedge sys_clk);
      if (s == 95) chk("B_even_parity", txd_a[1], 1);
      if (s == 85) chk("B_odd_parity", txd_a[2], 0);
      if (s == 109) chk("B_busy_last_clock", busy_a[1], 1);
    end
    chk("B_frame_end_d1", busy_a[1], 0);
    chk("B_frame_end_d2", busy_a[2], 0);
    wait_idle("B_drain", 500);

    // 0xFF on 7O2: seven ones, then parity 0 (bit 7 never sent), then 20 high clocks
    send1(8'hFF);
    @(negedge sys_clk);
    for (int s = 1; s <= 110; s++) begin
      @(negedge sys_clk);
      if (s % 10 == 5 && s >= 15 && s <= 75) chk($sformatf("C_data%0d", s / 10 - 1), txd_a[2], 1);
      if (s == 85) chk("C_bit7_not_sent", txd_a[2], 0);
      if (s == 95 || s == 105) chk("C_stop_high", txd_a[2], 1);
      if (s == 95) chk("C_even_parity_ff", txd_a[1], 0);
    end
    chk("C_frame_end", busy_a[2], 0);
    wait_idle("C_drain", 500);

    // Six held bytes into the depth-4 FIFO
    for (int b = 1; b <= 6; b++) begin
      tx_data  = 8'(b);
      tx_valid = 1'b1;
      t = 0;
      while (!ready_a[1] && t < 400) begin
        @(negedge sys_clk);
        t++;
      end
      @(negedge sys_clk);
      if (b == 1) acc0 = cyc;
      if (b == 2) chk("D_count_push_pop", cnt_a[1], 1);
      if (b == 5) begin
        chk("D_count_full", cnt_a[1], 4);
        chk("D_ready_low", ready_a[1], 0);
      end
      if (b == 6) chk("D_stall_cycles", cyc - acc0, 112);
    end
    tx_valid = 1'b0;
    t = 0;
    while (busy_a[1] && t < 2000) begin
      @(negedge sys_clk);
      t++;
    end
    chk("D_back_to_back_span", cyc - acc0, 661);
    wait_idle("D_drain", 3000);

    // Reset in the middle of a data bit with bytes queued
    for (int b = 0; b < 3; b++) begin
      tx_data  = 8'($urandom);
      tx_valid = 1'b1;
      @(negedge sys_clk);
    end
    tx_valid = 1'b0;
    repeat (25) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("R_txd%0d", k), txd_a[k], 1);
      chk($sformatf("R_count%0d", k), cnt_a[k], 0);
      chk($sformatf("R_ready%0d", k), ready_a[k], 1);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (200) @(negedge sys_clk);
    chk("R_no_resume", int'(busy_a), 0);
    chk("R_line_idle", int'(txd_a), 7);

    // Random traffic: dense first half, sparse second half
    for (int i = 0; i < 3000; i++) begin
      tx_valid = ($urandom_range(0, (i < 1500) ? 3 : 120) == 0);
      tx_data  = 8'($urandom);
      @(negedge sys_clk);
    end
    tx_valid = 1'b0;
    wait_idle("E_drain", 3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
